// File: rtl/clk_rst_seq_if.sv
// -----------------------------------------------------------------------------
// clk_rst_seq_if
// Groups the request inputs and the per-domain clock-enable/reset outputs of
// clk_rst_seq. The clock and power-on reset stay as plain ports on the module.
//
//   sys_rst_ni   system reset request, active-low, targets every channel
//   ndm_rst_ni   debug reset request, active-low, targets channels in ch_mask_i
//   pll_lock_i   PLL locked
//   ch_mask_i    channels affected by a debug reset
//   clk_enb_o    per-channel clock enable
//   rst_no       per-channel reset, active-low
//   busy_o       high whenever the sequencer is not in RUN
//   rst_cause_o  last reset cause: 00 por, 01 sys, 10 ndm, 11 pll unlock
//
// master: the side that drives the requests (PLL / reset controller / bench)
// slave : the sequencer itself
// -----------------------------------------------------------------------------
interface clk_rst_seq_if #(
   parameter int NUM_CH = 4
) ();
   logic              sys_rst_ni;
   logic              ndm_rst_ni;
   logic              pll_lock_i;
   logic [NUM_CH-1:0] ch_mask_i;
   logic [NUM_CH-1:0] clk_enb_o;
   logic [NUM_CH-1:0] rst_no;
   logic              busy_o;
   logic [1:0]        rst_cause_o;

   modport master (
      output sys_rst_ni,
      output ndm_rst_ni,
      output pll_lock_i,
      output ch_mask_i,
      input  clk_enb_o,
      input  rst_no,
      input  busy_o,
      input  rst_cause_o
   );

   modport slave (
      input  sys_rst_ni,
      input  ndm_rst_ni,
      input  pll_lock_i,
      input  ch_mask_i,
      output clk_enb_o,
      output rst_no,
      output busy_o,
      output rst_cause_o
   );
endinterface

// File: rtl/clk_rst_seq.sv
// -----------------------------------------------------------------------------
// clk_rst_seq
// Multi-domain clock-enable and reset sequencer. Holds the targeted domains
// gated and in reset while any reset request or a PLL unlock is present, waits
// HOLD_CYCLES after the last request clears, then releases the domains one at
// a time in index order, STAGGER cycles apart (clock enable first, reset one
// cycle later). Debug resets only touch the channels selected by ch_mask_i.
//
// Ports:
//   clk_i   system clock (PLL output)
//   rst_ni  power-on reset, synchronous, active-low
//   bus     clk_rst_seq_if.slave: requests in, clk_enb_o/rst_no/busy_o/
//           rst_cause_o out (all outputs registered)
//
// Parameters:
//   NUM_CH       number of domains (1..16)
//   CNT_W        width of the hold and stagger counters
//   HOLD_CYCLES  cycles spent in COUNT before the first release
//   STAGGER      cycles between successive channel releases (>= 2)
// -----------------------------------------------------------------------------
module clk_rst_seq #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int HOLD_CYCLES = 1000,
   parameter int STAGGER     = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   clk_rst_seq_if.slave  bus
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [NUM_CH-1:0] ALL_CH    = {NUM_CH{1'b1}};
   localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  STAG_LAST = CNT_W'(STAGGER - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CH - 1);

   localparam logic [1:0] CAUSE_POR = 2'b00;
   localparam logic [1:0] CAUSE_SYS = 2'b01;
   localparam logic [1:0] CAUSE_NDM = 2'b10;
   localparam logic [1:0] CAUSE_PLL = 2'b11;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK,
      ST_ASSERT,
      ST_COUNT,
      ST_STAGGER,
      ST_RUN
   } state_t;

   state_t            state_reg,  state_next;
   logic [NUM_CH-1:0] tgt_reg,    tgt_next;
   logic [CNT_W-1:0]  cnt_reg,    cnt_next;
   logic [CNT_W-1:0]  scnt_reg,   scnt_next;
   logic [IDX_W-1:0]  idx_reg,    idx_next;
   logic [1:0]        cause_reg,  cause_next;
   logic [NUM_CH-1:0] enb_reg,    enb_next;
   logic [NUM_CH-1:0] rstn_reg,   rstn_next;
   logic              busy_reg,   busy_next;

   // Per-cycle channel controls produced by the FSM and applied per channel.
   logic [NUM_CH-1:0] clr_mask;     // channels forced gated and in reset
   logic              enb_rel;      // release the clock enable of enb_rel_idx
   logic [IDX_W-1:0]  enb_rel_idx;
   logic              rst_rel;      // release the reset of idx_reg

   logic sys_req;
   logic ndm_req;
   logic any_req_low;

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg <= ST_WAIT_LOCK;
         tgt_reg   <= ALL_CH;
         cnt_reg   <= '0;
         scnt_reg  <= '0;
         idx_reg   <= '0;
         cause_reg <= CAUSE_POR;
         enb_reg   <= '0;
         rstn_reg  <= '0;
         busy_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         tgt_reg   <= tgt_next;
         cnt_reg   <= cnt_next;
         scnt_reg  <= scnt_next;
         idx_reg   <= idx_next;
         cause_reg <= cause_next;
         enb_reg   <= enb_next;
         rstn_reg  <= rstn_next;
         busy_reg  <= busy_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic. Requests are checked first in every state with the
   // priority pll unlock > sys > ndm; the per-state sequencing only runs on
   // cycles without an effective request.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      tgt_next    = tgt_reg;
      cnt_next    = cnt_reg;
      scnt_next   = scnt_reg;
      idx_next    = idx_reg;
      cause_next  = cause_reg;
      clr_mask    = '0;
      enb_rel     = 1'b0;
      enb_rel_idx = '0;
      rst_rel     = 1'b0;

      sys_req     = !bus.sys_rst_ni;
      // A debug reset with an empty mask has no target and is ignored.
      ndm_req     = !bus.ndm_rst_ni && (bus.ch_mask_i != '0);
      any_req_low = !bus.sys_rst_ni || !bus.ndm_rst_ni;

      if (!bus.pll_lock_i) begin
         state_next = ST_WAIT_LOCK;
         tgt_next   = ALL_CH;
         cause_next = CAUSE_PLL;
         cnt_next   = '0;
         clr_mask   = ALL_CH;
      end else if (sys_req) begin
         state_next = ST_ASSERT;
         tgt_next   = ALL_CH;
         cause_next = CAUSE_SYS;
         cnt_next   = '0;
         clr_mask   = ALL_CH;
      end else if (ndm_req) begin
         // The mask accumulates: an abort mid-stagger re-asserts every channel
         // of the old target as well as the newly requested ones.
         state_next = ST_ASSERT;
         tgt_next   = tgt_reg | bus.ch_mask_i;
         cause_next = CAUSE_NDM;
         cnt_next   = '0;
         clr_mask   = tgt_reg | bus.ch_mask_i;
      end else begin
         unique case (state_reg)
            ST_WAIT_LOCK,
            ST_ASSERT: begin
               // Leave only once both request lines are high; a held debug
               // request with an empty mask still keeps the domains waiting.
               if (!any_req_low) begin
                  state_next = ST_COUNT;
                  cnt_next   = '0;
               end
            end

            ST_COUNT: begin
               if (cnt_reg == HOLD_LAST) begin
                  // Entry edge of STAGGER: channel 0 gets its clock back here.
                  state_next  = ST_STAGGER;
                  idx_next    = '0;
                  scnt_next   = '0;
                  enb_rel     = 1'b1;
                  enb_rel_idx = '0;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end

            ST_STAGGER: begin
               // scnt_reg == 0 is the cycle right after a clock-enable release,
               // so the reset of the current channel follows one edge later.
               if (scnt_reg == '0) begin
                  rst_rel = 1'b1;
                  if (idx_reg == LAST_IDX) begin
                     state_next = ST_RUN;
                     tgt_next   = '0;
                  end
               end
               // STAGGER >= 2 keeps the enable release of the next channel on a
               // different cycle from the reset release of the current one.
               if (scnt_reg == STAG_LAST) begin
                  scnt_next   = '0;
                  idx_next    = idx_reg + IDX_W'(1);
                  enb_rel     = 1'b1;
                  enb_rel_idx = idx_reg + IDX_W'(1);
               end else begin
                  scnt_next = scnt_reg + CNT_W'(1);
               end
            end

            ST_RUN: begin
            end

            default: begin
               state_next = ST_WAIT_LOCK;
               tgt_next   = ALL_CH;
               clr_mask   = ALL_CH;
            end
         endcase
      end

      busy_next = (state_next != ST_RUN);
   end

   // -------------------------------------------------------------------------
   // Per-channel output update. A channel outside the target is never cleared
   // and is already high, so releasing it again during STAGGER is a no-op.
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_ch
         assign enb_next[gi]  = !clr_mask[gi] &&
                                (enb_reg[gi] || (enb_rel && (enb_rel_idx == IDX_W'(gi))));
         assign rstn_next[gi] = !clr_mask[gi] &&
                                (rstn_reg[gi] || (rst_rel && (idx_reg == IDX_W'(gi))));
      end
   endgenerate

   assign bus.clk_enb_o   = enb_reg;
   assign bus.rst_no      = rstn_reg;
   assign bus.busy_o      = busy_reg;
   assign bus.rst_cause_o = cause_reg;

endmodule

// File: tb/tb_clk_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_clk_rst_seq
// Directed, table-driven bench for clk_rst_seq (NUM_CH=4, HOLD_CYCLES=1000,
// STAGGER=8). Each table row applies one set of inputs and either checks the
// outputs after a fixed number of edges or follows a complete release window
// edge by edge against the expected release schedule. Aborts (PLL drop in
// COUNT, sys reset and power-on reset mid-stagger) are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_clk_rst_seq;

   localparam int NCH  = 4;
   localparam int HOLD = 1000;
   localparam int STG  = 8;
   // Last window index checked: a few edges past the RUN entry.
   localparam int FULL = HOLD + (NCH - 1) * STG + 3;

   logic clk;
   logic rst_n;

   int checks = 0;
   int errors = 0;

   clk_rst_seq_if #(.NUM_CH(NCH)) bus ();

   clk_rst_seq #(
      .NUM_CH      (NCH),
      .CNT_W       (16),
      .HOLD_CYCLES (HOLD),
      .STAGGER     (STG)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic           rst_n;
      logic           sys_n;
      logic           ndm_n;
      logic           lock;
      logic [NCH-1:0] mask;
      int             edges;   // mode 0: edges to apply before checking
      int             mode;    // 0: step and check, 1: follow a release window
      logic [NCH-1:0] tgt;     // mode 1: channels expected to be released
      logic [NCH-1:0] enb;
      logic [NCH-1:0] rstn;
      logic           busy;
      logic [1:0]     cause;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(input logic r, input logic s, input logic n, input logic l,
                               input logic [NCH-1:0] m, input int e, input int md,
                               input logic [NCH-1:0] t, input logic [NCH-1:0] en,
                               input logic [NCH-1:0] rn, input logic b, input logic [1:0] c);
      vec_t v;
      v.rst_n = r;  v.sys_n = s; v.ndm_n = n; v.lock = l; v.mask = m;
      v.edges = e;  v.mode = md; v.tgt = t;   v.enb = en; v.rstn = rn;
      v.busy  = b;  v.cause = c;
      return v;
   endfunction

   task automatic chk(input string name, input int id, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %0h, required %0h", name, id, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic n, input logic l,
                        input logic [NCH-1:0] m);
      rst_n          = r;
      bus.sys_rst_ni = s;
      bus.ndm_rst_ni = n;
      bus.pll_lock_i = l;
      bus.ch_mask_i  = m;
   endtask

   // Expected outputs j edges after COUNT entry (j=0 is the entry edge).
   function automatic void exp_at(input logic [NCH-1:0] tgt, input int j,
                                  output logic [NCH-1:0] e, output logic [NCH-1:0] r,
                                  output logic b);
      for (int k = 0; k < NCH; k++) begin
         if (tgt[k]) begin
            e[k] = (j >= HOLD + k * STG);
            r[k] = (j >= HOLD + k * STG + 1);
         end else begin
            e[k] = 1'b1;
            r[k] = 1'b1;
         end
      end
      b = (j < HOLD + (NCH - 1) * STG + 1);
   endfunction

   // Steps edges j=0..last_j from COUNT entry and compares every edge against
   // the schedule; the window counts as one comparison of its bad-edge count.
   task automatic run_release(input string name, input int id,
                              input logic [NCH-1:0] tgt, input int last_j);
      int             bad;
      int             first_j;
      logic [NCH-1:0] e, r, fe, fr;
      logic           b, fb;
      bad = 0; first_j = -1; fe = '0; fr = '0; fb = 1'b0;
      for (int j = 0; j <= last_j; j++) begin
         step(1);
         exp_at(tgt, j, e, r, b);
         if (bus.clk_enb_o !== e || bus.rst_no !== r || bus.busy_o !== b) begin
            if (bad == 0) begin
               first_j = j; fe = e; fr = r; fb = b;
            end
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s [%0d]: %0d bad edges, first at j=%0d required enb=%b rstn=%b busy=%b, required 0 bad edges",
                  name, id, bad, first_j, fe, fr, fb);
      end
   endtask

   initial begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, '0);

      //           rst  sys  ndm  lock mask     edg md tgt      enb      rstn     busy cause
      vecs[0]  = mk(1'b0,1'b1,1'b1,1'b1,4'b0000, 2, 0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'b00);
      vecs[1]  = mk(1'b1,1'b1,1'b1,1'b1,4'b0000, 0, 1, 4'b1111, 4'b1111, 4'b1111, 1'b0, 2'b00);
      vecs[2]  = mk(1'b1,1'b0,1'b1,1'b1,4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'b01);
      vecs[3]  = mk(1'b1,1'b0,1'b1,1'b1,4'b0000, 4, 0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'b01);
      vecs[4]  = mk(1'b1,1'b1,1'b1,1'b1,4'b0000, 0, 1, 4'b1111, 4'b1111, 4'b1111, 1'b0, 2'b01);
      vecs[5]  = mk(1'b1,1'b1,1'b0,1'b1,4'b0011, 1, 0, 4'b0000, 4'b1100, 4'b1100, 1'b1, 2'b10);
      vecs[6]  = mk(1'b1,1'b1,1'b1,1'b1,4'b0011, 0, 1, 4'b0011, 4'b1111, 4'b1111, 1'b0, 2'b10);
      vecs[7]  = mk(1'b1,1'b1,1'b0,1'b1,4'b0000, 3, 0, 4'b0000, 4'b1111, 4'b1111, 1'b0, 2'b10);
      vecs[8]  = mk(1'b1,1'b0,1'b0,1'b1,4'b0011, 1, 0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'b01);
      vecs[9]  = mk(1'b1,1'b1,1'b1,1'b1,4'b0000, 0, 1, 4'b1111, 4'b1111, 4'b1111, 1'b0, 2'b01);
      vecs[10] = mk(1'b1,1'b1,1'b0,1'b1,4'b1000, 2, 0, 4'b0000, 4'b0111, 4'b0111, 1'b1, 2'b10);
      vecs[11] = mk(1'b1,1'b1,1'b0,1'b1,4'b0001, 1, 0, 4'b0000, 4'b0110, 4'b0110, 1'b1, 2'b10);
      vecs[12] = mk(1'b1,1'b1,1'b1,1'b1,4'b0000, 0, 1, 4'b1001, 4'b1111, 4'b1111, 1'b0, 2'b10);

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].rst_n, vecs[i].sys_n, vecs[i].ndm_n, vecs[i].lock, vecs[i].mask);
         if (vecs[i].mode == 0) begin
            step(vecs[i].edges);
         end else begin
            run_release("release", i, vecs[i].tgt, FULL);
         end
         chk("clk_enb", i, 32'(bus.clk_enb_o),   32'(vecs[i].enb));
         chk("rst_n",   i, 32'(bus.rst_no),      32'(vecs[i].rstn));
         chk("busy",    i, 32'(bus.busy_o),      32'(vecs[i].busy));
         chk("cause",   i, 32'(bus.rst_cause_o), 32'(vecs[i].cause));
         $display("vec %0d: enb=%b rstn=%b busy=%b cause=%b", i,
                  bus.clk_enb_o, bus.rst_no, bus.busy_o, bus.rst_cause_o);
      end

      // PLL drop with the hold counter at 500: everything re-gated, and after
      // relock the full hold is served again from zero.
      drive(1'b1, 1'b0, 1'b1, 1'b1, '0);
      step(1);
      drive(1'b1, 1'b1, 1'b1, 1'b1, '0);
      run_release("pll_pre", 0, 4'b1111, 500);
      drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
      step(1);
      chk("pll_enb",   0, 32'(bus.clk_enb_o),   32'h0);
      chk("pll_rstn",  0, 32'(bus.rst_no),      32'h0);
      chk("pll_busy",  0, 32'(bus.busy_o),      32'h1);
      chk("pll_cause", 0, 32'(bus.rst_cause_o), 32'h3);
      step(2);
      chk("pll_hold_enb", 0, 32'(bus.clk_enb_o), 32'h0);
      drive(1'b1, 1'b1, 1'b1, 1'b1, '0);
      run_release("pll_relock", 0, 4'b1111, FULL);
      chk("pll_cause_run", 0, 32'(bus.rst_cause_o), 32'h3);
      $display("seq pll: enb=%b rstn=%b busy=%b cause=%b",
               bus.clk_enb_o, bus.rst_no, bus.busy_o, bus.rst_cause_o);

      // sys reset after channel 1 has been fully released mid-stagger.
      drive(1'b1, 1'b0, 1'b1, 1'b1, '0);
      step(1);
      drive(1'b1, 1'b1, 1'b1, 1'b1, '0);
      run_release("sys_pre", 1, 4'b1111, HOLD + STG + 2);
      chk("sys_mid_enb",  1, 32'(bus.clk_enb_o), 32'h3);
      chk("sys_mid_rstn", 1, 32'(bus.rst_no),    32'h3);
      drive(1'b1, 1'b0, 1'b1, 1'b1, '0);
      step(1);
      chk("sys_abort_enb",   1, 32'(bus.clk_enb_o),   32'h0);
      chk("sys_abort_rstn",  1, 32'(bus.rst_no),      32'h0);
      chk("sys_abort_cause", 1, 32'(bus.rst_cause_o), 32'h1);
      drive(1'b1, 1'b1, 1'b1, 1'b1, '0);
      run_release("sys_restart", 1, 4'b1111, FULL);
      $display("seq sys_abort: enb=%b rstn=%b busy=%b cause=%b",
               bus.clk_enb_o, bus.rst_no, bus.busy_o, bus.rst_cause_o);

      // Power-on reset mid-stagger (channel 1 enabled, still in reset).
      drive(1'b1, 1'b0, 1'b1, 1'b1, '0);
      step(1);
      drive(1'b1, 1'b1, 1'b1, 1'b1, '0);
      run_release("por_pre", 2, 4'b1111, HOLD + STG);
      chk("por_mid_enb", 2, 32'(bus.clk_enb_o), 32'h3);
      drive(1'b0, 1'b1, 1'b1, 1'b1, '0);
      step(1);
      chk("por_enb",   2, 32'(bus.clk_enb_o),   32'h0);
      chk("por_rstn",  2, 32'(bus.rst_no),      32'h0);
      chk("por_busy",  2, 32'(bus.busy_o),      32'h1);
      chk("por_cause", 2, 32'(bus.rst_cause_o), 32'h0);
      drive(1'b1, 1'b1, 1'b1, 1'b1, '0);
      run_release("por_restart", 2, 4'b1111, FULL);
      $display("seq por_abort: enb=%b rstn=%b busy=%b cause=%b",
               bus.clk_enb_o, bus.rst_no, bus.busy_o, bus.rst_cause_o);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
